bpm_report_uart_tx: RTL and testbench



---
 rtl/bpm_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 63 ++++++
 rtl/bpm_report_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_bpm_report_uart_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpm_pkg.sv
// Shared types and constants for the BPM UART report path.
package bpm_pkg;

    localparam int BPM_WIDTH  = 8;
    localparam int LINE_BYTES = 9;

    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Character at position idx of the line "BPM=HTO\r\n".
    function automatic logic [7:0] line_char(input logic [3:0] idx,
                                             input logic [3:0] h,
                                             input logic [3:0] t,
                                             input logic [3:0] o);
        logic [7:0] c;
        case (idx)
            4'd0:    c = ASCII_B;
            4'd1:    c = ASCII_P;
            4'd2:    c = ASCII_M;
            4'd3:    c = ASCII_EQ;
            4'd4:    c = ASCII_ZERO + {4'd0, h};
            4'd5:    c = ASCII_ZERO + {4'd0, t};
            4'd6:    c = ASCII_ZERO + {4'd0, o};
            4'd7:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, done 8 cycles after start.
module bin2bcd_seq
    import bpm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BPM_WIDTH-1:0] bin,
    output logic                 done,
    output logic [3:0]           hundreds,
    output logic [3:0]           tens,
    output logic [3:0]           ones
);

    logic [19:0] shift_reg;
    logic [3:0]  iter_cnt;
    logic        busy;

    // One shift-and-add-3 iteration over the BCD field in bits [19:8].
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // Iteration control and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            iter_cnt <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy     <= 1'b1;
                iter_cnt <= 4'd8;
            end else if (busy) begin
                iter_cnt <= iter_cnt - 4'd1;
                if (iter_cnt == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Conversion shift register (data only, no reset).
    always_ff @(posedge clk) begin
        if (start)
            shift_reg <= {12'd0, bin};
        else if (busy)
            shift_reg <= dabble_step(shift_reg);
    end

    assign hundreds = shift_reg[19:16];
    assign tens     = shift_reg[15:12];
    assign ones     = shift_reg[11:8];

endmodule

// File: rtl/bpm_report_uart_tx.sv
// Captures BPM results and transmits "BPM=NNN\r\n" lines over an 8N1 UART.
module bpm_report_uart_tx
    import bpm_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 10_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [BPM_WIDTH-1:0] bpm_latest,
    input  logic                 bpm_ready_out,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 overrun
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BYTE = 4'(LINE_BYTES - 1);

    tx_state_e            state, state_n;
    logic [CNT_W-1:0]     baud_cnt, baud_n;
    logic [2:0]           bit_idx, bit_n;
    logic [3:0]           byte_idx, byte_n;
    logic                 baud_wrap;
    logic                 ready_prev;
    logic                 evt;
    logic [BPM_WIDTH-1:0] cur_val, pend_val;
    logic                 pend_full;
    logic                 cvt_go;
    logic                 bcd_done;
    logic [3:0]           bcd_h, bcd_t, bcd_o;
    logic [3:0]           dig_h, dig_t, dig_o;
    logic [7:0]           char_n;
    logic                 tx_level_n;

    assign evt       = en & bpm_ready_out & ~ready_prev;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (cvt_go),
        .bin      (cur_val),
        .done     (bcd_done),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    // State register; the line level is registered from next-state so the pin is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            uart_tx  <= 1'b1;
            cvt_go   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            uart_tx  <= tx_level_n;
            cvt_go   <= (state == IDLE) && (state_n == CONVERT);
        end
    end

    // Next-state logic: conversion wait, then START/DATA/STOP per byte, 9 bytes per line.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        case (state)
            IDLE: begin
                baud_n = '0;
                bit_n  = 3'd0;
                byte_n = 4'd0;
                if (evt || pend_full)
                    state_n = CONVERT;
            end
            CONVERT: begin
                baud_n = '0;
                if (bcd_done)
                    state_n = START;
            end
            START: begin
                if (baud_wrap) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_n = bit_idx + 3'd1;
                end else begin
                    baud_n = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_n = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                    end else begin
                        byte_n  = byte_idx + 4'd1;
                        state_n = START;
                    end
                end else begin
                    baud_n = baud_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs: busy outside IDLE, and the line level for the upcoming cycle.
    always_comb begin
        tx_busy    = (state != IDLE);
        char_n     = line_char(byte_n, dig_h, dig_t, dig_o);
        tx_level_n = 1'b1;
        case (state_n)
            START:   tx_level_n = 1'b0;
            DATA:    tx_level_n = char_n[bit_n];
            default: tx_level_n = 1'b1;
        endcase
    end

    // Edge detector, pending-slot occupancy and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_prev <= 1'b0;
            pend_full  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ready_prev <= bpm_ready_out;
            overrun    <= 1'b0;
            if (state == IDLE) begin
                // Serving the slot empties it unless a new event refills it in the same cycle.
                if (pend_full && !evt)
                    pend_full <= 1'b0;
            end else if (evt) begin
                pend_full <= 1'b1;
                overrun   <= pend_full;
            end
        end
    end

    // Value capture: current line value, pending value and converted digits.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (pend_full)
                cur_val <= pend_val;
            else if (evt)
                cur_val <= bpm_latest;
            if (pend_full && evt)
                pend_val <= bpm_latest;
        end else if (evt) begin
            pend_val <= bpm_latest;
        end
        if (state == CONVERT && bcd_done) begin
            dig_h <= bcd_h;
            dig_t <= bcd_t;
            dig_o <= bcd_o;
        end
    end

endmodule

// File: tb/tb_bpm_report_uart_tx.sv
// Directed bench for bpm_report_uart_tx with a UART byte scoreboard.
module tb_bpm_report_uart_tx;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] bpm_latest;
    logic       bpm_ready_out;
    logic       uart_tx;
    logic       tx_busy;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    bpm_report_uart_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (250_000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bpm_latest    (bpm_latest),
        .bpm_ready_out (bpm_ready_out),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int v);
        sb.push_back(8'h42);
        sb.push_back(8'h50);
        sb.push_back(8'h4D);
        sb.push_back(8'h3D);
        sb.push_back(8'(8'h30 + v / 100));
        sb.push_back(8'(8'h30 + (v / 10) % 10));
        sb.push_back(8'(8'h30 + v % 10));
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    task automatic pulse(input int v);
        bpm_latest    = 8'(v);
        bpm_ready_out = 1'b1;
        @(posedge clk);
        #1;
        bpm_ready_out = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (tx_busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        chk("idle_timeout", 32'(n < 2000), 1);
    endtask

    // Called one sample after the event edge; returns total busy cycles of the line.
    task automatic measure(output int total);
        int lat;
        int n;
        lat = 0;
        while (uart_tx !== 1'b0 && lat < 20) begin
            tick();
            lat++;
        end
        chk("start_latency", lat, 10);
        wait_idle(n);
        total = lat + n;
    endtask

    task automatic run_line(input int v);
        int n;
        push_line(v);
        pulse(v);
        chk("busy_on_event", tx_busy, 1);
        measure(n);
        chk("line_busy_len", n, 370);
    endtask

    // UART receiver sampling at the falling edge, mid-bit.
    initial begin
        int         ph;
        logic       act;
        logic [7:0] b;
        logic [7:0] e;
        ph  = 0;
        act = 1'b0;
        b   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (uart_tx === 1'b0) begin
                    act = 1'b1;
                    ph  = 1;
                end
            end else begin
                if (ph >= 6 && ph <= 34 && ((ph - 6) % 4) == 0)
                    b[(ph - 6) / 4] = uart_tx;
                if (ph == 38) begin
                    chk("stop_bit", uart_tx, 1);
                    chk("byte_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rx_byte", b, e);
                    end
                end
                ph++;
                if (ph == 40)
                    act = 1'b0;
            end
        end
    end

    initial begin
        int n;
        rst           = 1'b1;
        en            = 1'b0;
        bpm_latest    = 8'd0;
        bpm_ready_out = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        en  = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            chk("idle_tx", uart_tx, 1);
            chk("idle_busy", tx_busy, 0);
            chk("idle_overrun", overrun, 0);
            tick();
        end

        // Single line, then boundary values
        run_line(72);
        tick();
        run_line(0);
        tick();
        run_line(255);
        tick();

        // Ready held as a level yields one line
        push_line(123);
        bpm_latest    = 8'd123;
        bpm_ready_out = 1'b1;
        repeat (50) tick();
        bpm_ready_out = 1'b0;
        wait_idle(n);
        repeat (20) tick();
        chk("level_single_line", tx_busy, 0);

        // Three events in one line: overrun on the third, latest value served next
        push_line(60);
        pulse(60);
        repeat (5) tick();
        pulse(61);
        chk("overrun_first_store", overrun, 0);
        repeat (5) tick();
        push_line(62);
        pulse(62);
        chk("overrun_pulse", overrun, 1);
        tick();
        chk("overrun_one_cycle", overrun, 0);
        wait_idle(n);
        tick();
        chk("pending_restart", tx_busy, 1);
        measure(n);
        chk("pending_line_len", n, 370);
        repeat (5) tick();

        // Disabled: events dropped
        en = 1'b0;
        pulse(200);
        repeat (20) tick();
        chk("en_low_busy", tx_busy, 0);
        chk("en_low_tx", uart_tx, 1);

        // Disable mid-line: line completes, event not stored
        en = 1'b1;
        push_line(150);
        pulse(150);
        repeat (100) tick();
        en = 1'b0;
        pulse(33);
        wait_idle(n);
        repeat (20) tick();
        chk("en_mid_no_pending", tx_busy, 0);
        en = 1'b1;

        // Reset in the middle of byte 3 data bits
        push_line(177);
        pulse(177);
        repeat (140) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_tx", uart_tx, 1);
        chk("rst_mid_busy", tx_busy, 0);
        sb.delete();
        rst = 1'b0;
        repeat (3) tick();
        run_line(99);

        repeat (50) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
